// File: rtl/program_loader_ram.sv
// -----------------------------------------------------------------------------
// program_loader_ram
//
// Writer side of the instruction store. A byte stream arrives over a
// valid/ready handshake: one count byte N (0 means 2**ADDR_W), then 3 bytes
// per instruction word (low byte, middle byte, top byte). The top byte
// contributes only its low 5 bits, and its upper 3 bits must be zero. Words are
// written sequentially from address 0 into an internal RAM. The CPU fetches
// through a combinational read port. CPU_HOLD keeps the CPU in reset while a
// load is in progress, and after a failed load.
//
// Optional feature (macro LOADER_CHECKSUM_EN):
//   defined   - a trailing checksum byte (8-bit sum of all data bytes) is
//               expected after the last word and compared before LOAD_OK.
//   undefined - the edge writing the last word completes the load.
//
// Ports:
//   CLK          system clock, rising edge
//   RESET        asynchronous, active-high reset
//   LOAD_START   one-cycle request to begin a load (ignored unless idle)
//   BYTE_IN      stream byte
//   BYTE_VALID   BYTE_IN valid
//   BYTE_READY   loader accepts a byte this cycle
//   RD_ADDR      CPU fetch address
//   RD_INSTR     instruction at RD_ADDR (combinational)
//   CPU_HOLD     keep CPU in reset
//   LOAD_OK      last load completed cleanly
//   LOAD_ERR     last load aborted
//   WORDS_LOADED words written in the current/last load
// -----------------------------------------------------------------------------
module program_loader_ram #(
    parameter int ADDR_W = 8,
    parameter int WORD_W = 21
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              LOAD_START,
    input  logic [7:0]        BYTE_IN,
    input  logic              BYTE_VALID,
    output logic              BYTE_READY,
    input  logic [ADDR_W-1:0] RD_ADDR,
    output logic [WORD_W-1:0] RD_INSTR,
    output logic              CPU_HOLD,
    output logic              LOAD_OK,
    output logic              LOAD_ERR,
    output logic [ADDR_W:0]   WORDS_LOADED
);

    localparam int DEPTH = 1 << ADDR_W;
    // A count byte of zero stands for a completely full RAM.
    localparam logic [ADDR_W:0] FULL_COUNT = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        COUNT = 3'd1,
        B0    = 3'd2,
        B1    = 3'd3,
        B2    = 3'd4
`ifdef LOADER_CHECKSUM_EN
        ,
        CSUM  = 3'd5
`endif
    } state_t;

    state_t              state_q, state_d;
    logic                cpu_hold_q, cpu_hold_d;
    logic                load_ok_q, load_ok_d;
    logic                load_err_q, load_err_d;
    logic [ADDR_W:0]     words_q, words_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [7:0]          byte0_q, byte0_d;
    logic [7:0]          byte1_q, byte1_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]          csum_q, csum_d;
`endif

    logic                accept;
    logic                wr_en;
    logic [WORD_W-1:0]   wr_data;
    logic [ADDR_W:0]     words_inc;

    logic [WORD_W-1:0]   mem [0:DEPTH-1];

    // Every non-idle state is waiting for a byte.
    assign BYTE_READY = (state_q != IDLE);
    assign accept     = BYTE_VALID && BYTE_READY;
    assign wr_data    = {BYTE_IN[4:0], byte1_q, byte0_q};
    assign words_inc  = words_q + (ADDR_W+1)'(1);

    always_comb begin
        state_d    = state_q;
        cpu_hold_d = cpu_hold_q;
        load_ok_d  = load_ok_q;
        load_err_d = load_err_q;
        words_d    = words_q;
        count_d    = count_q;
        ptr_d      = ptr_q;
        byte0_d    = byte0_q;
        byte1_d    = byte1_q;
`ifdef LOADER_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        wr_en      = 1'b0;

        case (state_q)
            IDLE: begin
                if (LOAD_START) begin
                    state_d    = COUNT;
                    cpu_hold_d = 1'b1;
                    load_ok_d  = 1'b0;
                    load_err_d = 1'b0;
                    words_d    = '0;
                    ptr_d      = '0;
`ifdef LOADER_CHECKSUM_EN
                    csum_d     = '0;
`endif
                end
            end
            COUNT: begin
                if (accept) begin
                    count_d = (BYTE_IN == 8'd0) ? FULL_COUNT : (ADDR_W+1)'(BYTE_IN);
                    state_d = B0;
                end
            end
            B0: begin
                if (accept) begin
                    byte0_d = BYTE_IN;
`ifdef LOADER_CHECKSUM_EN
                    csum_d  = csum_q + BYTE_IN;
`endif
                    state_d = B1;
                end
            end
            B1: begin
                if (accept) begin
                    byte1_d = BYTE_IN;
`ifdef LOADER_CHECKSUM_EN
                    csum_d  = csum_q + BYTE_IN;
`endif
                    state_d = B2;
                end
            end
            B2: begin
                if (accept) begin
`ifdef LOADER_CHECKSUM_EN
                    csum_d = csum_q + BYTE_IN;
`endif
                    if (BYTE_IN[7:5] != 3'b000) begin
                        // Malformed top byte: abort without writing; CPU stays held.
                        load_err_d = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        wr_en   = 1'b1;
                        ptr_d   = ptr_q + ADDR_W'(1);
                        words_d = words_inc;
                        if (words_inc == count_q) begin
`ifdef LOADER_CHECKSUM_EN
                            state_d    = CSUM;
`else
                            load_ok_d  = 1'b1;
                            cpu_hold_d = 1'b0;
                            state_d    = IDLE;
`endif
                        end else begin
                            state_d = B0;
                        end
                    end
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CSUM: begin
                if (accept) begin
                    if (BYTE_IN == csum_q) begin
                        load_ok_d  = 1'b1;
                        cpu_hold_d = 1'b0;
                    end else begin
                        load_err_d = 1'b1;
                    end
                    state_d = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= IDLE;
            cpu_hold_q <= 1'b0;
            load_ok_q  <= 1'b0;
            load_err_q <= 1'b0;
            words_q    <= '0;
            count_q    <= '0;
            ptr_q      <= '0;
            byte0_q    <= '0;
            byte1_q    <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cpu_hold_q <= cpu_hold_d;
            load_ok_q  <= load_ok_d;
            load_err_q <= load_err_d;
            words_q    <= words_d;
            count_q    <= count_d;
            ptr_q      <= ptr_d;
            byte0_q    <= byte0_d;
            byte1_q    <= byte1_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    // RAM contents survive reset; wr_en is already forced low while in reset
    // because the state register sits in IDLE.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[ptr_q] <= wr_data;
        end
    end

    assign RD_INSTR     = mem[RD_ADDR];
    assign CPU_HOLD     = cpu_hold_q;
    assign LOAD_OK      = load_ok_q;
    assign LOAD_ERR     = load_err_q;
    assign WORDS_LOADED = words_q;

endmodule

// File: tb/tb_program_loader_ram.sv
// -----------------------------------------------------------------------------
// tb_program_loader_ram
//
// Directed test of program_loader_ram: reset values, asynchronous reset during
// a load, continuous and gapped loads, malformed top byte, checksum mismatch
// (when LOADER_CHECKSUM_EN is defined) and a full 256-word load.
// -----------------------------------------------------------------------------
module tb_program_loader_ram;

    localparam int ADDR_W = 8;
    localparam int WORD_W = 21;

    logic              CLK = 1'b0;
    logic              RESET;
    logic              LOAD_START;
    logic [7:0]        BYTE_IN;
    logic              BYTE_VALID;
    logic              BYTE_READY;
    logic [ADDR_W-1:0] RD_ADDR;
    logic [WORD_W-1:0] RD_INSTR;
    logic              CPU_HOLD;
    logic              LOAD_OK;
    logic              LOAD_ERR;
    logic [ADDR_W:0]   WORDS_LOADED;

    int n_checks = 0;
    int n_fail   = 0;

    program_loader_ram #(.ADDR_W(ADDR_W), .WORD_W(WORD_W)) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .LOAD_START   (LOAD_START),
        .BYTE_IN      (BYTE_IN),
        .BYTE_VALID   (BYTE_VALID),
        .BYTE_READY   (BYTE_READY),
        .RD_ADDR      (RD_ADDR),
        .RD_INSTR     (RD_INSTR),
        .CPU_HOLD     (CPU_HOLD),
        .LOAD_OK      (LOAD_OK),
        .LOAD_ERR     (LOAD_ERR),
        .WORDS_LOADED (WORDS_LOADED)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
            $display("check %s: 0x%0h ok", tag, obs);
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic rd_chk(input string tag, input logic [ADDR_W-1:0] a, input logic [31:0] exp);
        RD_ADDR = a;
        #1;
        chk(tag, 32'(RD_INSTR), exp);
    endtask

    // Pulse LOAD_START for one cycle with BYTE_VALID low.
    task automatic pulse_start();
        @(negedge CLK);
        BYTE_VALID = 1'b0;
        LOAD_START = 1'b1;
        @(posedge CLK);
        #1;
        LOAD_START = 1'b0;
    endtask

    // Present one byte after 'gap' idle cycles; returns 1 time unit after the
    // accepting edge. BYTE_VALID is left high.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited;
        repeat (gap) begin
            @(negedge CLK);
            BYTE_VALID = 1'b0;
        end
        @(negedge CLK);
        BYTE_IN    = b;
        BYTE_VALID = 1'b1;
        waited     = 0;
        while (!BYTE_READY && waited < 20) begin
            @(negedge CLK);
            waited++;
        end
        if (!BYTE_READY) begin
            chk("byte_ready_timeout", 32'(BYTE_READY), 32'd1);
        end else begin
            @(posedge CLK);
            #1;
            $display("byte 0x%02h accepted, words_loaded=%0d hold=%0b", b, WORDS_LOADED, CPU_HOLD);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        RESET      = 1'b1;
        LOAD_START = 1'b0;
        BYTE_IN    = 8'h00;
        BYTE_VALID = 1'b0;
        RD_ADDR    = '0;
        #3;
        chk("rst_hold",  32'(CPU_HOLD),     32'd0);
        chk("rst_ok",    32'(LOAD_OK),      32'd0);
        chk("rst_err",   32'(LOAD_ERR),     32'd0);
        chk("rst_words", 32'(WORDS_LOADED), 32'd0);
        chk("rst_ready", 32'(BYTE_READY),   32'd0);
        @(negedge CLK);
        RESET = 1'b0;

        // ---- Asynchronous reset after 4 bytes ----
        pulse_start();
        chk("start_hold",  32'(CPU_HOLD),   32'd1);
        chk("start_ready", 32'(BYTE_READY), 32'd1);
        send_byte(8'h02, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h03, 0);
        chk("mid_words", 32'(WORDS_LOADED), 32'd1);
        RESET = 1'b1;
        #1;
        chk("arst_hold",  32'(CPU_HOLD),     32'd0);
        chk("arst_ok",    32'(LOAD_OK),      32'd0);
        chk("arst_err",   32'(LOAD_ERR),     32'd0);
        chk("arst_words", 32'(WORDS_LOADED), 32'd0);
        chk("arst_ready", 32'(BYTE_READY),   32'd0);
        rd_chk("arst_ram0_kept", 8'd0, 32'h032211);
        @(negedge CLK);
        RESET      = 1'b0;
        BYTE_VALID = 1'b0;

        // ---- Continuous load of two words ----
        pulse_start();
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h0C, 0);
        send_byte(8'h00, 0);
        send_byte(8'h18, 0);
        chk("cont_hold_before_last", 32'(CPU_HOLD), 32'd1);
        send_byte(8'h0C, 0);
`ifdef LOADER_CHECKSUM_EN
        chk("cont_hold_before_csum", 32'(CPU_HOLD), 32'd1);
        send_byte(8'h30, 0);
`endif
        chk("cont_hold",  32'(CPU_HOLD),     32'd0);
        chk("cont_ok",    32'(LOAD_OK),      32'd1);
        chk("cont_err",   32'(LOAD_ERR),     32'd0);
        chk("cont_words", 32'(WORDS_LOADED), 32'd2);
        chk("cont_ready", 32'(BYTE_READY),   32'd0);
        // BYTE_VALID is still high in IDLE: nothing may change.
        repeat (3) @(negedge CLK);
        chk("cont_idle_words", 32'(WORDS_LOADED), 32'd2);
        BYTE_VALID = 1'b0;
        rd_chk("cont_ram0", 8'd0, 32'h0C0000);
        rd_chk("cont_ram1", 8'd1, 32'h0C1800);

`ifdef LOADER_CHECKSUM_EN
        // ---- Same stream, wrong checksum ----
        pulse_start();
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h0C, 0);
        send_byte(8'h00, 0);
        send_byte(8'h18, 0);
        send_byte(8'h0C, 0);
        send_byte(8'h31, 0);
        BYTE_VALID = 1'b0;
        chk("bad_csum_err",   32'(LOAD_ERR),     32'd1);
        chk("bad_csum_ok",    32'(LOAD_OK),      32'd0);
        chk("bad_csum_hold",  32'(CPU_HOLD),     32'd1);
        chk("bad_csum_words", 32'(WORDS_LOADED), 32'd2);
        rd_chk("bad_csum_ram1", 8'd1, 32'h0C1800);
`endif

        // ---- Malformed top byte ----
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h2C, 0);
        BYTE_VALID = 1'b0;
        chk("type_err",   32'(LOAD_ERR),     32'd1);
        chk("type_ok",    32'(LOAD_OK),      32'd0);
        chk("type_hold",  32'(CPU_HOLD),     32'd1);
        chk("type_words", 32'(WORDS_LOADED), 32'd0);
        chk("type_ready", 32'(BYTE_READY),   32'd0);
        rd_chk("type_ram0", 8'd0, 32'h0C0000);
        repeat (2) @(negedge CLK);
        chk("type_hold_persist", 32'(CPU_HOLD), 32'd1);

        // ---- Overwrite word 0 so the gapped load is observable ----
        pulse_start();
        chk("restart_hold", 32'(CPU_HOLD), 32'd1);
        chk("restart_err",  32'(LOAD_ERR), 32'd0);
        send_byte(8'h01, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h03, 0);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h36, 0);
`endif
        BYTE_VALID = 1'b0;
        chk("pre_ok", 32'(LOAD_OK), 32'd1);
        rd_chk("pre_ram0", 8'd0, 32'h032211);

        // ---- Gapped load, idle bytes, mid-load LOAD_START ----
        @(negedge CLK);
        BYTE_IN    = 8'h05;
        BYTE_VALID = 1'b1;
        repeat (3) @(negedge CLK);
        chk("idle_ready", 32'(BYTE_READY), 32'd0);
        pulse_start();
        send_byte(8'h02, 2);
        send_byte(8'h00, 2);
        send_byte(8'h00, 2);
        send_byte(8'h0C, 2);
        pulse_start();
        send_byte(8'h00, 2);
        send_byte(8'h18, 2);
        send_byte(8'h0C, 2);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h30, 2);
`endif
        BYTE_VALID = 1'b0;
        chk("gap_ok",    32'(LOAD_OK),      32'd1);
        chk("gap_err",   32'(LOAD_ERR),     32'd0);
        chk("gap_hold",  32'(CPU_HOLD),     32'd0);
        chk("gap_words", 32'(WORDS_LOADED), 32'd2);
        rd_chk("gap_ram0", 8'd0, 32'h0C0000);
        rd_chk("gap_ram1", 8'd1, 32'h0C1800);

        // ---- Full RAM: count 0 means 256 words, word k = k ----
        pulse_start();
        send_byte(8'h00, 0);
        for (int k = 0; k < 256; k++) begin
            send_byte(8'(k), 0);
            send_byte(8'h00, 0);
            if (k == 255) begin
                chk("full_words_before_last", 32'(WORDS_LOADED), 32'd255);
                chk("full_hold_before_last",  32'(CPU_HOLD),     32'd1);
            end
            send_byte(8'h00, 0);
        end
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h80, 0);
`endif
        BYTE_VALID = 1'b0;
        chk("full_words", 32'(WORDS_LOADED), 32'd256);
        chk("full_ok",    32'(LOAD_OK),      32'd1);
        chk("full_hold",  32'(CPU_HOLD),     32'd0);
        for (int k = 0; k < 256; k++) begin
            rd_chk("full_ram", 8'(k), 32'(k));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/program_loader_ram.md
Name: program_loader_ram

Overview:
Writer side of the instruction store. Receives a byte stream over a valid/ready handshake and packs every 3 bytes into one 21-bit instruction word. Writes the words sequentially into an internal RAM from address 0. The CPU fetches from the RAM through an asynchronous read port. CPU_HOLD drives the system RESET input, so the CPU is held in reset while a program loads.

Parameters:
ADDR_W, 8, address width; RAM depth = 2**ADDR_W words
WORD_W, 21, instruction width; fixed format [20:19] type, [18] I/R, [17:14] opcode, [13:11] tgt, [10:8] A, [7:0] B/imm

Ports:
CLK  input  1  system clock, rising edge
RESET  input  1  asynchronous, active-high
LOAD_START  input  1  one-cycle request to begin a load
BYTE_IN  input  8  stream byte
BYTE_VALID  input  1  BYTE_IN valid
BYTE_READY  output  1  loader accepts a byte this cycle
RD_ADDR  input  ADDR_W  CPU fetch address
RD_INSTR  output  WORD_W  instruction at RD_ADDR (combinational)
CPU_HOLD  output  1  keep CPU in reset
LOAD_OK  output  1  last load completed cleanly
LOAD_ERR  output  1  last load aborted
WORDS_LOADED  output  ADDR_W+1  words written in current/last load

Behaviour:
- Byte transfer: a byte is accepted when BYTE_VALID && BYTE_READY at a CLK edge. BYTE_READY is high only in states COUNT, B0, B1, B2, CSUM.
- Reset values: state IDLE, CPU_HOLD=0, LOAD_OK=0, LOAD_ERR=0, WORDS_LOADED=0, word pointer=0, checksum=0. RAM contents are not reset.
- RESET asserted mid-load: immediate return to IDLE with the reset values above. RAM keeps any partially written words.
- IDLE:
  - LOAD_START -> COUNT.
  - On that edge: CPU_HOLD=1, LOAD_OK=0, LOAD_ERR=0, WORDS_LOADED=0, pointer=0, checksum=0.
  - BYTE_VALID in IDLE is not accepted.
- COUNT: accepted byte N is the word count. N=0 means 2**ADDR_W. -> B0.
- B0: accepted byte -> word[7:0]. -> B1.
- B1: accepted byte -> word[15:8]. -> B2.
- B2: accepted byte b.
  - If b[7:5]!=0: LOAD_ERR=1 -> IDLE, nothing written, CPU_HOLD stays 1.
  - Else on the same edge: RAM[pointer]={b[4:0],word[15:0]}, pointer+1, WORDS_LOADED+1.
  - If WORDS_LOADED reaches N -> CSUM (or DONE without macro), else -> B0.
- Checksum is the 8-bit sum mod 256 of all data bytes (not the count byte), updated on each accepted B0/B1/B2 byte.
- CSUM: accepted byte compared with the checksum.
  - Match: LOAD_OK=1, CPU_HOLD=0 -> IDLE.
  - Mismatch: LOAD_ERR=1, CPU_HOLD stays 1 -> IDLE.
- CPU_HOLD after an error stays high until the next LOAD_START begins a load (then still 1) or RESET.
- LOAD_START while not IDLE: ignored.
- Pointer wraps at 2**ADDR_W. With N=0, word 2**ADDR_W-1 is the last word written; no wrap write occurs.
- Read port: RD_INSTR=RAM[RD_ADDR], combinational. A write to the same address becomes visible after the write edge.
- Latency:
  - Minimum load time = 1 + 3N (+1 with checksum) accepted bytes.
  - CPU_HOLD falls on the edge accepting the final byte.

Optional Feature:
Macro LOADER_CHECKSUM_EN.
- Defined: CSUM state and trailing checksum byte as above.
- Undefined: CSUM state absent. The edge writing word N sets LOAD_OK=1, CPU_HOLD=0 and returns to IDLE. The checksum register is not implemented.

Test Plan:
- RESET pulse mid-load (after 4 bytes) -> CPU_HOLD=0, LOAD_OK=0, LOAD_ERR=0, WORDS_LOADED=0, BYTE_READY=0 asynchronously. LOAD_START still works afterwards.
- LOAD_START, then bytes 02, 00,00,0C, 00,18,0C, 30 (checksum) with BYTE_VALID held high -> RAM[0]=0x0C0000, RAM[1]=0x0C1800, WORDS_LOADED=2, LOAD_OK=1, CPU_HOLD 1 then 0 after the final byte.
- Same stream with checksum byte 31 -> LOAD_ERR=1, LOAD_OK=0, CPU_HOLD=1. Both words are still written.
- Count 01, bytes 00,00,2C (b[7:5]=001) -> LOAD_ERR=1 after the third data byte, WORDS_LOADED=0, RAM[0] unchanged, state IDLE (BYTE_READY=0).
- Gapped BYTE_VALID (valid every 3rd cycle), LOAD_START pulsed mid-load, BYTE_VALID high in IDLE -> identical RAM and flags to the continuous case. Mid-load LOAD_START has no effect; idle bytes are not accepted.
- Count 00 with 256 words, data = address -> RAM[k]=k for k=0..255, WORDS_LOADED=256, LOAD_OK=1.
